lu_sweep: RTL

Sequential driver and capture stage for the 2-input selectable logic unit (AND/NAND/OR/NOR, selected by `key1`/`key2`). On `start`, the block steps through all 16 combinations of `{key1,key2,x,y}`. It drives them into the logic unit, waits a programmable settle time, samples the unit's result `r`, and packs the results into a 16-bit truth-table word. It sits directly upstream of the logic unit, whose `x`/`y`/`key1`/`key2` inputs it feeds, and it consumes the unit's `r` output.

---
 rtl/lu_sweep.sv | 119 +++++++++++
 1 files changed

// File: rtl/lu_sweep.sv
// Sweeps all 16 {key1,key2,y,x} vectors through the selectable logic unit and packs r into a truth table.
// Optional golden-model checker (err_cnt/err) is enabled by defining LU_SWEEP_CHECK_EN.
module lu_sweep #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        r,
    output logic        x,
    output logic        y,
    output logic        key1,
    output logic        key2,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [3:0]  idx
`ifdef LU_SWEEP_CHECK_EN
    ,
    output logic [4:0]  err_cnt,
    output logic        err
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE_W,
        SAMPLE,
        FIN
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = DRIVE;
            DRIVE:    state_next = (SETTLE == 0) ? SAMPLE : SETTLE_W;
            SETTLE_W: if (wait_cnt == 4'd0) state_next = SAMPLE;
            SAMPLE:   state_next = (idx == 4'd15) ? FIN : DRIVE;
            FIN:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // idx and truth_table are only cleared by an accepted start, so a finished table survives idle time
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= 4'd0;
            truth_table <= 16'h0000;
            wait_cnt    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx         <= 4'd0;
                        truth_table <= 16'h0000;
                    end
                end
                DRIVE:    wait_cnt <= WAIT_LOAD;
                SETTLE_W: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                SAMPLE: begin
                    truth_table[idx] <= r;
                    if (idx != 4'd15) idx <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign x    = idx[0];
    assign y    = idx[1];
    assign key2 = idx[2];
    assign key1 = idx[3];
    assign busy = (state == DRIVE) || (state == SETTLE_W) || (state == SAMPLE);
    assign done = (state == FIN);

`ifdef LU_SWEEP_CHECK_EN
    logic expected_r;

    always_comb begin
        expected_r = 1'b0;
        case ({key1, key2})
            2'b00: expected_r = x & y;
            2'b01: expected_r = ~(x & y);
            2'b10: expected_r = x | y;
            2'b11: expected_r = ~(x | y);
            default: expected_r = 1'b0;
        endcase
    end

    // Saturates at 16 even though a single sweep can never exceed that count
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 5'd0;
        end else if (state == IDLE && start) begin
            err_cnt <= 5'd0;
        end else if (state == SAMPLE && r != expected_r && err_cnt != 5'd16) begin
            err_cnt <= err_cnt + 5'd1;
        end
    end

    assign err = done && (err_cnt != 5'd0);
`endif

endmodule
